// File: rtl/omp_frame_collector.sv
// Ping-pong capture buffer: absorbs an unordered pixel write stream per frame, zero-fills
// unwritten pixels and streams completed frames out in raster order over valid/ready.
module omp_frame_collector #(
  parameter int unsigned PIX_W  = 24,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pixel_we,
  input  logic [ADDR_W-1:0] pixel_addr,
  input  logic [PIX_W-1:0]  pixel_val,
  input  logic              frame_done,
  output logic              wr_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PIX_W-1:0]  out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic [CNT_W-1:0]  frames_out,
  output logic              dup_err,
  output logic              drop_err
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LastIdx = '1;

  typedef enum logic [1:0] {BkEmpty, BkFilling, BkFull, BkReading} bank_st_e;

  bank_st_e          bank_st_q [2];
  bank_st_e          bank_st_d [2];
  logic [Depth-1:0]  mask_q [2];
  logic [Depth-1:0]  mask_d [2];
  logic [PIX_W-1:0]  ram_q [2][Depth];

  logic              fill_bank_q, fill_bank_d;
  logic              wr_ready_q, wr_ready_d;
  logic              iss_bank_q, iss_bank_d;
  logic              iss_run_q, iss_run_d;
  logic [ADDR_W-1:0] iss_idx_q, iss_idx_d;
  logic              free_bank_q, free_bank_d;

  logic              s1_vld_q, s1_vld_d, s1_last_q;
  logic [PIX_W-1:0]  s1_data_q;
  logic [ADDR_W-1:0] s1_addr_q;

  logic              out_valid_q, out_last_q;
  logic [PIX_W-1:0]  out_data_q;
  logic [ADDR_W-1:0] out_addr_q;
  logic [CNT_W-1:0]  frames_q;
  logic              dup_q, drop_q;

  logic s2_ready, s1_ready, iss_start, iss_fire, iss_last, hs_last;
  logic wr_acc, close, other_free;

  always_comb begin
    s2_ready   = !out_valid_q || out_ready;
    s1_ready   = !s1_vld_q || s2_ready;
    iss_start  = !iss_run_q && (bank_st_q[iss_bank_q] == BkFull);
    iss_fire   = (iss_run_q || iss_start) && s1_ready;
    iss_last   = iss_fire && (iss_idx_q == LastIdx);
    hs_last    = out_valid_q && out_ready && out_last_q;
    wr_acc     = wr_ready_q && pixel_we;
    close      = wr_ready_q && frame_done;
    // The other bank counts as free if its last pixel is handed off on this very edge
    other_free = (bank_st_q[!fill_bank_q] == BkEmpty) ||
                 (hs_last && (free_bank_q == !fill_bank_q));
    s1_vld_d   = iss_fire ? 1'b1 : (s2_ready ? 1'b0 : s1_vld_q);

    bank_st_d   = bank_st_q;
    mask_d      = mask_q;
    fill_bank_d = fill_bank_q;
    wr_ready_d  = wr_ready_q;
    iss_bank_d  = iss_bank_q;
    iss_run_d   = iss_run_q;
    iss_idx_d   = iss_idx_q;
    free_bank_d = free_bank_q;

    if (iss_start) begin
      bank_st_d[iss_bank_q] = BkReading;
      iss_run_d             = 1'b1;
    end
    // Issue pointer moves on as soon as the last read is issued so the next frame has no gap
    if (iss_last) begin
      iss_run_d  = 1'b0;
      iss_bank_d = !iss_bank_q;
      iss_idx_d  = '0;
    end else if (iss_fire) begin
      iss_idx_d = iss_idx_q + ADDR_W'(1);
    end

    if (hs_last) begin
      bank_st_d[free_bank_q] = BkEmpty;
      free_bank_d            = !free_bank_q;
      if (!wr_ready_q) begin
        bank_st_d[free_bank_q] = BkFilling;
        mask_d[free_bank_q]    = '0;
        fill_bank_d            = free_bank_q;
        wr_ready_d             = 1'b1;
      end
    end

    if (wr_acc) mask_d[fill_bank_q][pixel_addr] = 1'b1;

    if (close) begin
      bank_st_d[fill_bank_q] = BkFull;
      if (other_free) begin
        bank_st_d[!fill_bank_q] = BkFilling;
        mask_d[!fill_bank_q]    = '0;
        fill_bank_d             = !fill_bank_q;
      end else begin
        wr_ready_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bank_st_q[0] <= BkFilling;
      bank_st_q[1] <= BkEmpty;
      mask_q[0]    <= '0;
      mask_q[1]    <= '0;
      fill_bank_q  <= 1'b0;
      wr_ready_q   <= 1'b1;
      iss_bank_q   <= 1'b0;
      iss_run_q    <= 1'b0;
      iss_idx_q    <= '0;
      free_bank_q  <= 1'b0;
      frames_q     <= '0;
      dup_q        <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      bank_st_q   <= bank_st_d;
      mask_q      <= mask_d;
      fill_bank_q <= fill_bank_d;
      wr_ready_q  <= wr_ready_d;
      iss_bank_q  <= iss_bank_d;
      iss_run_q   <= iss_run_d;
      iss_idx_q   <= iss_idx_d;
      free_bank_q <= free_bank_d;
      if (hs_last) frames_q <= frames_q + CNT_W'(1);
      if (wr_acc && mask_q[fill_bank_q][pixel_addr]) dup_q <= 1'b1;
      if (!wr_ready_q && (pixel_we || frame_done)) drop_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) ram_q[fill_bank_q][pixel_addr] <= pixel_val;
  end

  // Stage 1 holds synchronous RAM read data; stage 2 is the output register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld_q    <= 1'b0;
      s1_data_q   <= '0;
      s1_addr_q   <= '0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      s1_vld_q <= s1_vld_d;
      if (iss_fire) begin
        s1_data_q <= mask_q[iss_bank_q][iss_idx_q] ? ram_q[iss_bank_q][iss_idx_q] : '0;
        s1_addr_q <= iss_idx_q;
        s1_last_q <= (iss_idx_q == LastIdx);
      end
      if (s2_ready) begin
        out_valid_q <= s1_vld_q;
        if (s1_vld_q) begin
          out_data_q <= s1_data_q;
          out_addr_q <= s1_addr_q;
          out_last_q <= s1_last_q;
        end
      end
    end
  end

  assign wr_ready   = wr_ready_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_addr   = out_addr_q;
  assign out_last   = out_last_q;
  assign frames_out = frames_q;
  assign dup_err    = dup_q;
  assign drop_err   = drop_q;

endmodule

// File: doc/omp_frame_collector.md
# omp_frame_collector

Parametrised capture buffer behind `omp_system_top`. It absorbs the unordered `pixel_we`/`pixel_addr`/`pixel_val` write stream of one reconstruction. Pixels never written in a frame are zero-filled. Completed frames stream out in raster order over a valid/ready port. Two ping-pong banks let the next reconstruction be written while the previous frame drains.

## Interface
- `PIX_W`, 24, pixel value width
- `ADDR_W`, 6, pixel address width; frame holds `2**ADDR_W` pixels (default 64 = 8x8)
- `CNT_W`, 8, width of the completed-frame counter
- `clk`  in  1  sole clock; all logic on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `pixel_we`  in  1  write strobe from reconstruction core
- `pixel_addr`  in  ADDR_W  write address
- `pixel_val`  in  PIX_W  write data
- `frame_done`  in  1  one-cycle pulse closing the current frame (driven from `done_all`)
- `wr_ready`  out  1  a bank is open for writing
- `out_valid`  out  1  output pixel valid
- `out_ready`  in  1  downstream accepts output pixel
- `out_data`  out  PIX_W  pixel value, 0 if unwritten in that frame
- `out_addr`  out  ADDR_W  raster index of `out_data`
- `out_last`  out  1  high with index `2**ADDR_W-1`
- `frames_out`  out  CNT_W  frames fully drained, wraps modulo `2**CNT_W`
- `dup_err`  out  1  sticky: an address was written twice within one frame
- `drop_err`  out  1  sticky: a write or `frame_done` arrived while `wr_ready`=0

## Operation
- Each bank has a `PIX_W`-wide RAM of `2**ADDR_W` words plus a `2**ADDR_W`-bit written-mask.
- Each bank is in one of four states: EMPTY, FILLING, FULL, READING.
- Reset state: bank0 FILLING with mask cleared, bank1 EMPTY.
- Write side, while one bank is FILLING (`wr_ready`=1):
  - `pixel_we` writes RAM[`pixel_addr`] and sets mask[`pixel_addr`].
  - If the mask bit was already set, the new value overwrites the old one and `dup_err` sets.
- `frame_done` moves the FILLING bank to FULL.
  - A `pixel_we` in the same cycle belongs to the closing frame.
  - `frame_done` with no writes yields an all-zero frame.
- After a frame closes, the other bank becomes FILLING with its mask cleared if it is EMPTY. Otherwise `wr_ready`=0.
- While `wr_ready`=0:
  - `pixel_we` and `frame_done` are discarded and `drop_err` sets.
  - No stored data changes.
- Read side: when idle and a bank is FULL, that bank goes to READING and the read index starts at 0.
- Each index is presented as `out_data` = mask[i] ? RAM[i] : 0, with `out_addr`=i.
- Frames are emitted strictly in completion order (oldest FULL bank first).
- After the handshake of index `2**ADDR_W-1`:
  - The bank goes to EMPTY and `frames_out` increments.
  - If the writer is blocked, that bank becomes FILLING immediately.
- A single-bank write/read conflict is impossible by construction. The FILLING and READING banks are always distinct.
- `dup_err`/`drop_err` clear only on reset.

## Timing
- Reset values:
  - `wr_ready`=1
  - `out_valid`=0, `out_data`=0, `out_addr`=0, `out_last`=0
  - `frames_out`=0, `dup_err`=0, `drop_err`=0
  - All masks cleared.
- Reset asserted mid-frame or mid-readout abandons both banks. Outputs return to reset values on the next edge.
- RAM write: 1 cycle. RAM read: synchronous, 1 cycle. The output register is fed through a one-entry skid so that zero bubbles occur under continuous `out_ready`.
- Latency: `frame_done` at edge T with the read side idle gives `out_valid`=1 at edge T+2, index 0.
- Throughput: 1 pixel/cycle while `out_ready`=1. A frame drains in `2**ADDR_W` cycles (64 by default).
- Handshake rules:
  - `out_valid` never drops without a handshake.
  - `out_data`, `out_addr` and `out_last` are stable while `out_valid`=1 and `out_ready`=0.
- Between frames:
  - When the next bank is already FULL, its index 0 follows the previous `out_last` handshake with no gap cycle.
  - `wr_ready` rises on the edge after the freeing `out_last` handshake.
- Errors and counters:
  - `dup_err`/`drop_err` assert on the edge after the offending input.
  - `frames_out` updates on the edge after the `out_last` handshake.

## Test plan
- Basic order: reset, write addr 5=0x00ABCD and addr 63=0x123456, pulse `frame_done`, hold `out_ready`=1.
  - 64 outputs, indices 0..63.
  - Index 5 = 0x00ABCD, index 63 = 0x123456 with `out_last`=1, all others 0.
  - First `out_valid` at T+2; `frames_out`=1.
- Backpressure: same frame, `out_ready` toggled pseudo-randomly.
  - Data and address stay stable while stalled; no index skipped or repeated.
- Ping-pong: frame A written and closed while `out_ready`=0; frame B written and closed; then `out_ready`=1.
  - A drains fully, then B, with no gap; `wr_ready`=0 after B closes.
  - A write issued then is dropped and sets `drop_err`.
  - `wr_ready`=1 the edge after A's `out_last` handshake.
- Duplicate and same-cycle close: write addr 3=0x1, then addr 3=0x2 together with `frame_done`.
  - `dup_err`=1; index 3 reads 0x2.
- Empty frame plus reset mid-readout: `frame_done` with no writes gives 64 zeros.
  - Asserting `rst_n`=0 at index 20 returns all outputs to reset values.
  - After release, `wr_ready`=1 and `frames_out`=0.
- Parameter sweep: `ADDR_W`=4, `PIX_W`=8, with random addresses checked against a scoreboard; `out_last` lands at index 15.
